gfx256_fragment: RTL
====================

// Module: gfx256_fragment
// PURPOSE
//  Fragment stage directly downstream of the clip/z-cull stage. Accepts one surviving pixel at a
//  time. In flat mode it forwards the pixel; in textured mode it fetches one 32-bit texel at
//  (u,v) through a read-request port and substitutes it as the pixel colour. The result goes to
//  the blender/writer. It acks the clip stage only after the downstream stage has acked.
// PARAMETERS
//  point_width  16  width of x/y/z/u/v coordinates and texture sizes
// PORTS
//  clk_i            in   1   clock; one clock domain
//  rst_ni           in   1   reset; asynchronous, active-low
//  texture_enable_i in   1   1 = textured fragment, 0 = flat colour
//  tex_base_i       in   32  texture byte base address
//  tex_size_x_i     in   pw  texture width in texels (>=1)
//  tex_size_y_i     in   pw  texture height in texels (>=1)
//  pixel_x_i/_y_i/_z_i in pw pixel coordinates/depth from clip
//  u_i, v_i         in   pw  texel coordinates from clip
//  a_i              in   8   pixel alpha from clip
//  color_i          in   32  flat colour from clip
//  write_i          in   1   pixel valid from clip; held high until ack_o seen
//  ack_o            out  1   one-cycle pulse: pixel consumed
//  tex_request_o    out  1   texel read request, held until tex_ack_i
//  tex_addr_o       out  32  texel byte address, stable while tex_request_o=1
//  tex_ack_i        in   1   read done; tex_data_i valid this cycle
//  tex_data_i       in   32  texel (ARGB8888)
//  pixel_x_o/_y_o/_z_o out pw pixel to blender
//  color_o          out  32  final colour
//  a_o              out  8   final alpha
//  write_o          out  1   pixel valid to blender, held until ack_i
//  ack_i            in   1   blender consumed pixel (single-cycle pulse)
// BEHAVIOUR
//  - Reset (rst_ni=0, async): state=IDLE; all outputs 0, including ack_o, write_o,
//    tex_request_o, tex_addr_o, color_o, a_o and pixel_*_o. Reset mid-fetch drops the request
//    immediately. A late tex_ack_i after reset is ignored.
//  - All outputs are registered. States are IDLE, ADDR, TREAD, WRITE, DONE.
//  - IDLE: if write_i=1, latch pixel_*, a_i and color_i.
//    - If texture_enable_i=1, latch u_i/v_i and go to ADDR.
//    - Otherwise set color_o=color_i, a_o=a_i and go to WRITE.
//    - texture_enable_i is sampled only at accept.
//  - ADDR (1 cycle):
//    - Clamp coordinates: uc = (u>=size_x) ? size_x-1 : u; vc likewise against size_y.
//    - tex_addr_o = tex_base_i + ((vc*size_x + uc) << 2), all in 32 bits, wrapping mod 2^32.
//    - Set tex_request_o=1 and go to TREAD.
//  - TREAD: hold request and address. On tex_ack_i: color_o=tex_data_i, a_o=a_i,
//    tex_request_o=0, go to WRITE. Latency from accept to write_o is 3 cycles plus memory wait.
//  - WRITE: write_o=1. On ack_i: write_o=0, ack_o=1 for one cycle, go to DONE.
//  - DONE (1 cycle): ignore write_i, because the clip stage deasserts write_i one cycle after
//    ack_o. Return to IDLE with ack_o=0. Back-to-back pixels are never accepted twice.
//  - Flat path: accept in cycle 0, write_o=1 in cycle 1, ack_o 1 cycle after ack_i.
//    Minimum pixel period is 4 cycles.
//  - ack_i while write_o=0 and tex_ack_i outside TREAD are ignored.
//  - pixel_*_o are stable from write_o rise until ack_i.
// CONFIGURATION
//  GFX_TEX_ALPHA_EN defined:
//    - Textured path: a_o = (a_i*tex_data_i[31:24] + 255) >> 8, with a 16-bit product.
//    - Check values: 255,255 -> 255; 0,x -> 0; 128,255 -> 128.
//    - Flat path is unchanged.
//  GFX_TEX_ALPHA_EN undefined: a_o = a_i always and texel alpha is discarded.
// TESTING
//  1 Flat: write_i, color_i=32'h00FF8000, a_i=8'h80.
//    -> write_o in cycle 1 with color_o=00FF8000 and a_o=80.
//    -> ack_i held off 5 cycles: outputs stable.
//    -> ack_o pulses exactly once, the cycle after ack_i.
//  2 Textured: base=32'h1000, size 64x64, u=3, v=2.
//    -> tex_addr_o=32'h1000+(2*64+3)*4=32'h120C.
//    -> tex_ack_i after 7 cycles with tex_data_i=32'hFF112233 -> color_o=FF112233.
//  3 Clamp: u=70, v=100, size 64x32 -> address uses (63,31) = base+(31*64+63)*4.
//    Base=32'hFFFFFFF0 with offset 16 wraps to 32'h0.
//  4 Handshake: write_i held high through DONE -> exactly one accept and one ack_o per pixel.
//    Back-to-back flat pixels give a 4-cycle period.
//  5 Reset mid-TREAD: rst_ni low -> tex_request_o, write_o and ack_o are 0 asynchronously.
//    Then a stray tex_ack_i in IDLE -> no write_o.
//  6 GFX_TEX_ALPHA_EN on: a_i=128, texel alpha 255 -> a_o=128; a_i=255, texel alpha 0 -> a_o=0.
//    Macro off: a_o=a_i.

Source files
------------

// File: rtl/gfx256_fragment_if.sv
// Signal bundle between clip stage, texture memory and blender around gfx256_fragment.
interface gfx256_fragment_if #(parameter int point_width = 16);
  logic                   texture_enable_i;
  logic [31:0]            tex_base_i;
  logic [point_width-1:0] tex_size_x_i;
  logic [point_width-1:0] tex_size_y_i;
  logic [point_width-1:0] pixel_x_i;
  logic [point_width-1:0] pixel_y_i;
  logic [point_width-1:0] pixel_z_i;
  logic [point_width-1:0] u_i;
  logic [point_width-1:0] v_i;
  logic [7:0]             a_i;
  logic [31:0]            color_i;
  logic                   write_i;
  logic                   ack_o;
  logic                   tex_request_o;
  logic [31:0]            tex_addr_o;
  logic                   tex_ack_i;
  logic [31:0]            tex_data_i;
  logic [point_width-1:0] pixel_x_o;
  logic [point_width-1:0] pixel_y_o;
  logic [point_width-1:0] pixel_z_o;
  logic [31:0]            color_o;
  logic [7:0]             a_o;
  logic                   write_o;
  logic                   ack_i;

  modport master (
    output texture_enable_i, tex_base_i, tex_size_x_i, tex_size_y_i,
           pixel_x_i, pixel_y_i, pixel_z_i, u_i, v_i, a_i, color_i, write_i,
           tex_ack_i, tex_data_i, ack_i,
    input  ack_o, tex_request_o, tex_addr_o,
           pixel_x_o, pixel_y_o, pixel_z_o, color_o, a_o, write_o
  );

  modport slave (
    input  texture_enable_i, tex_base_i, tex_size_x_i, tex_size_y_i,
           pixel_x_i, pixel_y_i, pixel_z_i, u_i, v_i, a_i, color_i, write_i,
           tex_ack_i, tex_data_i, ack_i,
    output ack_o, tex_request_o, tex_addr_o,
           pixel_x_o, pixel_y_o, pixel_z_o, color_o, a_o, write_o
  );
endinterface

// File: rtl/gfx256_fragment.sv
// Fragment stage: flat colour pass-through or one clamped texel fetch per pixel; GFX_TEX_ALPHA_EN modulates alpha by texel alpha.
// Accept->write_o: 1 cycle flat, 3 + memory wait textured; clip ack_o is withheld until the blender acks.
module gfx256_fragment #(
  parameter int point_width = 16
) (
  input logic              clk_i,
  input logic              rst_ni,
  gfx256_fragment_if.slave bus
);

  typedef enum logic [2:0] {IDLE, ADDR, TREAD, WRITE, DONE} state_t;

  state_t                 state, state_nx;
  logic                   accept, tex_done, blend_done;
  logic [point_width-1:0] u_lat, v_lat, uc, vc;
  logic [point_width-1:0] pixel_x, pixel_y, pixel_z;
  logic [7:0]             a_lat, alpha, tex_alpha;
  logic [31:0]            color, tex_addr, texel_idx, addr_nx;
  logic                   write, ack, tex_request;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    accept     = 1'b0;
    tex_done   = 1'b0;
    blend_done = 1'b0;
    case (state)
      IDLE: if (bus.write_i) begin
        accept   = 1'b1;
        state_nx = bus.texture_enable_i ? ADDR : WRITE;
      end
      ADDR:  state_nx = TREAD;
      TREAD: if (bus.tex_ack_i) begin
        tex_done = 1'b1;
        state_nx = WRITE;
      end
      WRITE: if (bus.ack_i) begin
        blend_done = 1'b1;
        state_nx   = DONE;
      end
      // write_i is still the old pixel here; the clip stage drops it next cycle
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Out-of-range texel coordinates clamp to the last row/column
  assign uc = (u_lat >= bus.tex_size_x_i) ? bus.tex_size_x_i - point_width'(1) : u_lat;
  assign vc = (v_lat >= bus.tex_size_y_i) ? bus.tex_size_y_i - point_width'(1) : v_lat;
  assign texel_idx = 32'(vc) * 32'(bus.tex_size_x_i) + 32'(uc);
  assign addr_nx   = bus.tex_base_i + (texel_idx << 2);

`ifdef GFX_TEX_ALPHA_EN
  assign tex_alpha = 8'((a_lat * bus.tex_data_i[31:24] + 16'd255) >> 8);
`else
  assign tex_alpha = a_lat;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pixel_x     <= '0;
      pixel_y     <= '0;
      pixel_z     <= '0;
      u_lat       <= '0;
      v_lat       <= '0;
      a_lat       <= '0;
      alpha       <= '0;
      color       <= '0;
      tex_addr    <= '0;
      tex_request <= 1'b0;
      write       <= 1'b0;
      ack         <= 1'b0;
    end else begin
      ack <= blend_done;
      if (accept) begin
        pixel_x <= bus.pixel_x_i;
        pixel_y <= bus.pixel_y_i;
        pixel_z <= bus.pixel_z_i;
        u_lat   <= bus.u_i;
        v_lat   <= bus.v_i;
        a_lat   <= bus.a_i;
        alpha   <= bus.a_i;
        color   <= bus.color_i;
        write   <= !bus.texture_enable_i;
      end
      if (state == ADDR) begin
        tex_addr    <= addr_nx;
        tex_request <= 1'b1;
      end
      if (tex_done) begin
        color       <= bus.tex_data_i;
        alpha       <= tex_alpha;
        tex_request <= 1'b0;
        write       <= 1'b1;
      end
      if (blend_done) write <= 1'b0;
    end
  end

  assign bus.pixel_x_o     = pixel_x;
  assign bus.pixel_y_o     = pixel_y;
  assign bus.pixel_z_o     = pixel_z;
  assign bus.color_o       = color;
  assign bus.a_o           = alpha;
  assign bus.write_o       = write;
  assign bus.ack_o         = ack;
  assign bus.tex_request_o = tex_request;
  assign bus.tex_addr_o    = tex_addr;

endmodule
